// File: rtl/ram_1p_host_arb.sv
// Two-host round-robin arbiter in front of a single-port 32-bit RAM with a fixed one-cycle
// response. Define RAM_ARB_RANGE_CHK_EN to answer out-of-window accesses with an error.
module ram_1p_host_arb #(
  parameter int unsigned Depth    = 128,
  parameter logic [31:0] BaseAddr = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  host_req_i,
  output logic [1:0]  host_gnt_o,
  input  logic [1:0]  host_we_i,
  input  logic [7:0]  host_be_i,
  input  logic [63:0] host_addr_i,
  input  logic [63:0] host_wdata_i,
  output logic [1:0]  host_rvalid_o,
  output logic [31:0] host_rdata_o,
  output logic [1:0]  host_err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [31:0] WinBytes = 32'(Depth * 4);

  if ((BaseAddr % WinBytes) != 0) begin : g_base_misaligned
    $error("BaseAddr must be aligned to Depth*4");
  end

  logic last_q, last_d;
  logic pend_q, pend_d;
  logic own_q, own_d;
  logic err_q, err_d;

  logic        any_req;
  logic        win;
  logic        acc_err;
  logic        rsp_vld;
  logic [31:0] win_addr;
  logic [31:0] win_off;

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    win = 1'b0;
    case (host_req_i)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
    // Grants are held off during reset so the RAM never sees a request while state clears.
    any_req  = (|host_req_i) && !rst_i;
    win_addr = win ? host_addr_i[63:32] : host_addr_i[31:0];
    win_off  = win_addr - BaseAddr;
`ifdef RAM_ARB_RANGE_CHK_EN
    acc_err  = (win_off >= WinBytes);
`else
    acc_err  = 1'b0;
`endif
    last_d = any_req ? win : last_q;
    pend_d = any_req;
    own_d  = win;
    err_d  = any_req && acc_err;
  end

  assign host_gnt_o  = any_req ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign ram_req_o   = any_req && !acc_err;
  assign ram_we_o    = win ? host_we_i[1] : host_we_i[0];
  assign ram_be_o    = win ? host_be_i[7:4] : host_be_i[3:0];
  assign ram_addr_o  = win_off;
  assign ram_wdata_o = win ? host_wdata_i[63:32] : host_wdata_i[31:0];

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
      pend_q <= 1'b0;
      own_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      pend_q <= pend_d;
      own_q  <= own_d;
      err_q  <= err_d;
    end
  end

  // A response in flight when reset rises is dropped in that same cycle.
  assign rsp_vld       = pend_q && !rst_i;
  assign host_rvalid_o = rsp_vld ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign host_err_o    = (rsp_vld && err_q) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign host_rdata_o  = (rsp_vld && !err_q) ? ram_rdata_i : 32'h0;

  a_no_stray_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    ram_rvalid_i |-> pend_q);
  a_ack_on_time: assert property (@(posedge clk_i) disable iff (rst_i)
    (pend_q && !err_q) |-> ram_rvalid_i);

endmodule

// File: tb/tb_ram_1p_host_arb.sv
// Scoreboard bench for ram_1p_host_arb: behavioural RAM, round-robin model, response queue.
module tb_ram_1p_host_arb;

  localparam int unsigned Depth    = 128;
  localparam logic [31:0] BaseAddr = 32'h0;
  localparam logic [31:0] WinBytes = 32'(Depth * 4);
`ifdef RAM_ARB_RANGE_CHK_EN
  localparam bit RangeChk = 1'b1;
`else
  localparam bit RangeChk = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  host_req_i;
  logic [1:0]  host_gnt_o;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_addr_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_rvalid_o;
  logic [31:0] host_rdata_o;
  logic [1:0]  host_err_o;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;

  ram_1p_host_arb #(.Depth(Depth), .BaseAddr(BaseAddr)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  host_oh;
    logic [31:0] data;
    logic        err;
    logic        is_wr;
    int unsigned due;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] ram_mem[Depth];
  logic [31:0] shadow[Depth];
  logic        m_last;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  // Behavioural single-port RAM: one-cycle ack, byte-enabled writes.
  always @(posedge clk_i) begin
    logic [31:0] merged;
    if (rst_i) begin
      ram_rvalid_i <= 1'b0;
    end else begin
      ram_rvalid_i <= ram_req_o;
      if (ram_req_o) begin
        ram_rdata_i <= ram_mem[ram_addr_o[8:2]];
        if (ram_we_o) begin
          merged = ram_mem[ram_addr_o[8:2]];
          for (int b = 0; b < 4; b++)
            if (ram_be_o[b]) merged[8*b +: 8] = ram_wdata_o[8*b +: 8];
          ram_mem[ram_addr_o[8:2]] <= merged;
        end
      end
    end
  end

  always @(posedge clk_i) cyc++;

  // Response side of the scoreboard: due entries are compared, otherwise the bus must be idle.
  always @(negedge clk_i) begin
    resp_t r;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      n_checks++;
      if (host_rvalid_o !== r.host_oh) begin
        n_fail++;
        $display("FAIL rsp_rvalid cyc=%0d: got %b expected %b", cyc, host_rvalid_o, r.host_oh);
      end
      n_checks++;
      if (host_err_o !== (r.err ? r.host_oh : 2'b00)) begin
        n_fail++;
        $display("FAIL rsp_err cyc=%0d: got %b expected %b", cyc, host_err_o,
                 r.err ? r.host_oh : 2'b00);
      end
      if (!r.is_wr) begin
        n_checks++;
        if (host_rdata_o !== r.data) begin
          n_fail++;
          $display("FAIL rsp_rdata cyc=%0d: got %h expected %h", cyc, host_rdata_o, r.data);
        end
      end
    end else begin
      n_checks++;
      if (host_rvalid_o !== 2'b00 || host_err_o !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_rsp cyc=%0d: got rvalid=%b err=%b expected 00/00",
                 cyc, host_rvalid_o, host_err_o);
      end
    end
  end

  function automatic logic [1:0] exp_gnt(input logic [1:0] req);
    case (req)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return m_last ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Records the expected response of the access granted this cycle and advances the model.
  task automatic accept(input logic [1:0] g);
    resp_t       r;
    logic        h;
    logic [31:0] off;
    logic [6:0]  idx;
    logic [31:0] w;
    if (g == 2'b00) return;
    h   = g[1];
    off = (h ? host_addr_i[63:32] : host_addr_i[31:0]) - BaseAddr;
    idx = off[8:2];
    r.host_oh = g;
    r.err     = RangeChk && (off >= WinBytes);
    r.is_wr   = host_we_i[h];
    if (r.is_wr && !r.err) begin
      w = shadow[idx];
      for (int b = 0; b < 4; b++)
        if (host_be_i[4*h + b]) w[8*b +: 8] = host_wdata_i[32*h + 8*b +: 8];
      shadow[idx] = w;
    end
    r.data = r.err ? 32'h0 : shadow[idx];
    r.due  = cyc + 1;
    sb.push_back(r);
    m_last = h;
  endtask

  task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] we,
                       input logic [7:0] be, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1);
    @(posedge clk_i);
    #1;
    rst_i        = rst;
    host_req_i   = req;
    host_we_i    = we;
    host_be_i    = be;
    host_addr_i  = {a1, a0};
    host_wdata_i = {wd1, wd0};
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b11, 2'b00, 8'hff, 32'h0, 32'h4, 32'h0, 32'h0);
    n_checks++;
    if (host_rvalid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rvalid: got %b expected 00", host_rvalid_o);
    end
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
    m_last = 1'b1;
    n_checks++;
    if (host_gnt_o !== 2'b00 || ram_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b ram_req=%b expected 00/0", host_gnt_o, ram_req_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq[4];
    logic [1:0] e;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b11, 2'b00, 8'hff, 32'h40 + 4*i, 32'h80 + 4*i, 32'h0, 32'h0);
      e = exp_gnt(2'b11);
      n_checks++;
      if (host_gnt_o !== seq[i] || host_gnt_o !== e) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got %b expected %b", i, host_gnt_o, seq[i]);
      end
      n_checks++;
      if (ram_addr_o !== (seq[i][1] ? 32'h80 + 4*i : 32'h40 + 4*i) || ram_req_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_addr[%0d]: got %h req=%b expected %h req=1", i, ram_addr_o, ram_req_o,
                 seq[i][1] ? 32'h80 + 4*i : 32'h40 + 4*i);
      end
      accept(e);
    end
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_single_read();
    drive(1'b0, 2'b01, 2'b00, 8'h0f, 32'h10, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (host_gnt_o !== 2'b01 || ram_req_o !== 1'b1 || ram_we_o !== 1'b0 ||
        ram_addr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL single_read: got gnt=%b req=%b we=%b addr=%h expected 01/1/0/00000010",
               host_gnt_o, ram_req_o, ram_we_o, ram_addr_o);
    end
    accept(exp_gnt(2'b01));
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_write_read();
    drive(1'b0, 2'b10, 2'b10, 8'h30, 32'h0, 32'h20, 32'h0, 32'hA5A5_1234);
    n_checks++;
    if (host_gnt_o !== 2'b10 || ram_we_o !== 1'b1 || ram_be_o !== 4'b0011 ||
        ram_wdata_o !== 32'hA5A5_1234 || ram_addr_o !== 32'h20) begin
      n_fail++;
      $display("FAIL write_mux: got gnt=%b we=%b be=%b wd=%h addr=%h expected 10/1/0011/a5a51234/20",
               host_gnt_o, ram_we_o, ram_be_o, ram_wdata_o, ram_addr_o);
    end
    accept(exp_gnt(2'b10));
    drive(1'b0, 2'b01, 2'b00, 8'h0f, 32'h20, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (host_gnt_o !== 2'b01 || ram_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_gnt: got gnt=%b we=%b expected 01/0", host_gnt_o, ram_we_o);
    end
    accept(exp_gnt(2'b01));
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] req;
    logic [1:0] e;
    for (int i = 0; i < 24; i++) begin
      req = 2'($urandom_range(0, 3));
      drive(1'b0, req, 2'($urandom_range(0, 3)), 8'($urandom),
            32'($urandom_range(0, Depth - 1)) << 2, 32'($urandom_range(0, Depth - 1)) << 2,
            $urandom, $urandom);
      e = exp_gnt(req);
      n_checks++;
      if (host_gnt_o !== e || ram_req_o !== (|e)) begin
        n_fail++;
        $display("FAIL b2b_gnt[%0d] req=%b: got gnt=%b ram_req=%b expected %b/%b",
                 i, req, host_gnt_o, ram_req_o, e, |e);
      end
      accept(e);
    end
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_range();
    drive(1'b0, 2'b10, 2'b00, 8'hf0, 32'h0, 32'h200, 32'h0, 32'h0);
    n_checks++;
    if (host_gnt_o !== 2'b10 || ram_req_o !== !RangeChk) begin
      n_fail++;
      $display("FAIL range_req: got gnt=%b ram_req=%b expected 10/%b",
               host_gnt_o, ram_req_o, !RangeChk);
    end
    if (!RangeChk) begin
      n_checks++;
      if (ram_addr_o !== 32'h200) begin
        n_fail++;
        $display("FAIL range_addr: got %h expected 00000200", ram_addr_o);
      end
    end
    accept(exp_gnt(2'b10));
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_in_flight();
    drive(1'b0, 2'b01, 2'b00, 8'h0f, 32'h10, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (host_gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rif_gnt: got %b expected 01", host_gnt_o);
    end
    drive(1'b1, 2'b11, 2'b00, 8'h00, 32'h0, 32'h4, 32'h0, 32'h0);
    n_checks++;
    if (host_rvalid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rif_discard: got rvalid=%b expected 00", host_rvalid_o);
    end
    m_last = 1'b1;
    drive(1'b0, 2'b11, 2'b00, 8'hff, 32'h8, 32'hc, 32'h0, 32'h0);
    n_checks++;
    if (host_gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rif_first_gnt: got %b expected 01", host_gnt_o);
    end
    accept(exp_gnt(2'b11));
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    m_last       = 1'b1;
    rst_i        = 1'b1;
    host_req_i   = 2'b00;
    host_we_i    = 2'b00;
    host_be_i    = 8'h00;
    host_addr_i  = 64'h0;
    host_wdata_i = 64'h0;
    for (int i = 0; i < int'(Depth); i++) begin
      ram_mem[i] = 32'hC0DE_0000 + 32'(i * 32'h0101);
      shadow[i]  = 32'hC0DE_0000 + 32'(i * 32'h0101);
    end

    test_reset();
    test_round_robin();
    test_single_read();
    test_write_read();
    test_back_to_back();
    test_range();
    test_reset_in_flight();

    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding responses expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
